// File: rtl/serial_parity_tx.sv
// Serial frame transmitter: start(0), DATA_W data bits LSB first, parity, stop(1),
// each bit held BIT_CYCLES clocks. Word accepted over a valid/ready handshake in IDLE.
module serial_parity_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (state_q == S_IDLE) begin
            if (in_valid) begin
                shift_d = in_data;
                par_d   = (^in_data) ^ ODD_BIT;
                cnt_d   = '0;
                state_d = S_START;
            end
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            case (state_q)
                S_START: begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = S_PARITY;
                end
                S_PARITY: state_d = S_STOP;
                S_STOP: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // tx is registered from the next state so the start bit appears right after the accept edge
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);
    assign in_ready = (state_q == S_IDLE);

endmodule
